// File: rtl/bsg_kda_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bsg_kda_pkg : shared types for the KDA job scheduler                |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package bsg_kda_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } sched_state_e;

  // Index of the set bit in a one-hot vector; 0 when the vector is empty.
  function automatic int unsigned onehot_to_idx(input logic [31:0] oh);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bsg_kda_rr_pick.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bsg_kda_rr_pick : round-robin one-hot picker with take-advanced ptr |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module bsg_kda_rr_pick #(
  parameter int width_p = 4
) (
  input  logic               clk_i,
  input  logic               async_reset_n_i,
  input  logic [width_p-1:0] mask_i,
  input  logic               take_i,
  output logic [width_p-1:0] grant_o
);

  localparam int c_PTR_W = (width_p > 1) ? $clog2(width_p) : 1;
  localparam logic [c_PTR_W:0]   c_WIDTH = (c_PTR_W + 1)'(width_p);
  localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(width_p - 1);

  logic [c_PTR_W-1:0] r_ptr;
  logic [c_PTR_W-1:0] w_ptr_next;
  logic [c_PTR_W:0]   w_sum;
  logic [c_PTR_W-1:0] w_idx;
  logic               w_found;

  // r_ptr is the highest-priority index; it moves just past the last grant.
  always_comb begin
    grant_o    = '0;
    w_ptr_next = r_ptr;
    w_found    = 1'b0;
    w_sum      = '0;
    w_idx      = '0;
    for (int i = 0; i < width_p; i++) begin
      w_sum = {1'b0, r_ptr} + (c_PTR_W + 1)'(i);
      if (w_sum >= c_WIDTH) w_sum = w_sum - c_WIDTH;
      w_idx = w_sum[c_PTR_W-1:0];
      if (!w_found && mask_i[w_idx]) begin
        grant_o[w_idx] = 1'b1;
        w_found        = 1'b1;
        w_ptr_next     = (w_idx == c_LAST) ? '0 : w_idx + c_PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge async_reset_n_i) begin
    if (!async_reset_n_i) begin
      r_ptr <= '0;
    end else if (take_i && w_found) begin
      r_ptr <= w_ptr_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bsg_kda_job_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bsg_kda_job_scheduler : dispatches PBKDF2 jobs to KDA master nodes, |
// | collects results, and guards progress with a watchdog. Rev 1.0      |
// +--------------------------------------------------------------------+
module bsg_kda_job_scheduler
  import bsg_kda_pkg::*;
#(
  parameter int nodes_p         = 4,
  parameter int job_width_p     = 32,
  parameter int result_width_p  = 32,
  parameter int jobs_width_p    = 16,
  parameter int timeout_width_p = 20
) (
  input  logic                               clk_i,
  input  logic                               async_reset_n_i,
  input  logic                               start_i,
  input  logic [jobs_width_p-1:0]            total_jobs_i,
  input  logic                               job_v_i,
  input  logic [job_width_p-1:0]             job_data_i,
  output logic                               job_ready_o,
  output logic [nodes_p-1:0]                 node_v_o,
  output logic [job_width_p-1:0]             node_data_o,
  input  logic [nodes_p-1:0]                 node_ready_i,
  input  logic [nodes_p-1:0]                 node_done_i,
  input  logic [nodes_p*result_width_p-1:0]  node_result_i,
  output logic [nodes_p-1:0]                 node_yumi_o,
  output logic                               result_v_o,
  output logic [result_width_p-1:0]          result_data_o,
  output logic [$clog2(nodes_p)-1:0]         result_node_o,
  input  logic                               result_yumi_i,
  output logic [nodes_p-1:0]                 busy_o,
  output logic [jobs_width_p-1:0]            jobs_done_o,
  output logic                               all_done_o,
  output logic                               timeout_o
);

  localparam int c_ID_W = $clog2(nodes_p);

  sched_state_e                r_state;
  logic [jobs_width_p-1:0]     r_total;
  logic [jobs_width_p-1:0]     r_issued;
  logic [jobs_width_p-1:0]     r_jobs_done;
  logic                        r_all_done;
  logic                        r_timeout;
  logic [nodes_p-1:0]          r_busy;
  logic [nodes_p-1:0]          r_node_v;
  logic [job_width_p-1:0]      r_node_data;
  logic                        r_result_v;
  logic [result_width_p-1:0]   r_result_data;
  logic [c_ID_W-1:0]           r_result_node;
  logic [timeout_width_p-1:0]  r_wdog;

  logic                        w_run;
  logic                        w_active;
  logic                        w_error;
  logic                        w_start_ok;
  logic [nodes_p-1:0]          w_free;
  logic                        w_dispatch;
  logic [nodes_p-1:0]          w_disp_grant;
  logic [nodes_p-1:0]          w_disp_set;
  logic [nodes_p-1:0]          w_collect_mask;
  logic [nodes_p-1:0]          w_col_grant;
  logic                        w_can_load;
  logic                        w_load;
  logic                        w_consume;
  logic [result_width_p-1:0]   w_col_data;
  logic [c_ID_W-1:0]           w_col_idx;
  logic                        w_wdog_clr;
  logic                        w_wdog_fire;

  assign w_run      = (r_state == RUN);
  assign w_active   = (r_state == RUN) || (r_state == DRAIN);
  assign w_error    = (r_state == ERROR);
  assign w_start_ok = start_i && ((r_state == IDLE) || (r_state == DONE));

  // A node pulsed last cycle is not yet reflected in node_ready_i, so mask it out.
  assign w_free      = node_ready_i & ~r_busy & ~r_node_v;
  assign job_ready_o = w_run && (|w_free) && (r_issued < r_total);
  assign w_dispatch  = job_v_i && job_ready_o;
  assign w_disp_set  = w_dispatch ? w_disp_grant : '0;

  bsg_kda_rr_pick #(.width_p(nodes_p)) dispatch_pick (
    .clk_i           (clk_i),
    .async_reset_n_i (async_reset_n_i),
    .mask_i          (w_free),
    .take_i          (w_dispatch),
    .grant_o         (w_disp_grant)
  );

  assign w_collect_mask = node_done_i & r_busy;
  assign w_can_load     = !r_result_v || result_yumi_i;
  assign w_load         = !w_error && w_can_load && (|w_collect_mask);
  assign w_consume      = !w_error && r_result_v && result_yumi_i;
  assign node_yumi_o    = w_load ? w_col_grant : '0;

  bsg_kda_rr_pick #(.width_p(nodes_p)) collect_pick (
    .clk_i           (clk_i),
    .async_reset_n_i (async_reset_n_i),
    .mask_i          (w_collect_mask),
    .take_i          (w_load),
    .grant_o         (w_col_grant)
  );

  always_comb begin
    w_col_data = '0;
    for (int k = 0; k < nodes_p; k++) begin
      if (w_col_grant[k]) w_col_data = w_col_data | node_result_i[k*result_width_p +: result_width_p];
    end
  end

  assign w_col_idx = c_ID_W'(onehot_to_idx(32'(w_col_grant)));

  // Any forward progress, or nothing outstanding, rearms the watchdog.
  assign w_wdog_clr  = (|node_yumi_o) || w_dispatch || !(|r_busy);
  assign w_wdog_fire = w_active && (&r_wdog) && !w_wdog_clr;

  always_ff @(posedge clk_i or negedge async_reset_n_i) begin
    if (!async_reset_n_i) begin
      r_state     <= IDLE;
      r_total     <= '0;
      r_issued    <= '0;
      r_jobs_done <= '0;
      r_all_done  <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      if (w_dispatch) r_issued <= r_issued + 1'b1;
      if (w_consume && (r_jobs_done < r_total)) r_jobs_done <= r_jobs_done + 1'b1;
      case (r_state)
        IDLE, DONE: begin
          if (start_i) begin
            r_total     <= total_jobs_i;
            r_issued    <= '0;
            r_jobs_done <= '0;
            if (total_jobs_i == '0) begin
              r_state    <= DONE;
              r_all_done <= 1'b1;
            end else begin
              r_state    <= RUN;
              r_all_done <= 1'b0;
            end
          end
        end
        RUN: begin
          if (w_wdog_fire) begin
            r_state   <= ERROR;
            r_timeout <= 1'b1;
          end else if (r_issued == r_total) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_wdog_fire) begin
            r_state   <= ERROR;
            r_timeout <= 1'b1;
          end else if (r_jobs_done == r_total) begin
            r_state    <= DONE;
            r_all_done <= 1'b1;
          end
        end
        ERROR:   r_state <= ERROR;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge async_reset_n_i) begin
    if (!async_reset_n_i) begin
      r_busy        <= '0;
      r_node_v      <= '0;
      r_node_data   <= '0;
      r_result_v    <= 1'b0;
      r_result_data <= '0;
      r_result_node <= '0;
      r_wdog        <= '0;
    end else begin
      // Collect clears before dispatch sets, so a same-node overlap leaves busy set.
      r_busy   <= (r_busy & ~node_yumi_o) | w_disp_set;
      r_node_v <= w_disp_set;
      if (w_dispatch) r_node_data <= job_data_i;
      if (w_load) begin
        r_result_v    <= 1'b1;
        r_result_data <= w_col_data;
        r_result_node <= w_col_idx;
      end else if (w_consume) begin
        r_result_v <= 1'b0;
      end
      if (w_wdog_clr || w_start_ok) begin
        r_wdog <= '0;
      end else if (w_active) begin
        r_wdog <= r_wdog + 1'b1;
      end
    end
  end

  assign node_v_o      = r_node_v;
  assign node_data_o   = r_node_data;
  assign result_v_o    = r_result_v;
  assign result_data_o = r_result_data;
  assign result_node_o = r_result_node;
  assign busy_o        = r_busy;
  assign jobs_done_o   = r_jobs_done;
  assign all_done_o    = r_all_done;
  assign timeout_o     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_bsg_kda_job_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_bsg_kda_job_scheduler : directed bench with a simple node model  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_bsg_kda_job_scheduler;

  localparam int NODES = 4;
  localparam int JW    = 32;
  localparam int RW    = 32;
  localparam int CW    = 16;
  localparam int TW    = 8;
  localparam logic [31:0] JOB_BASE = 32'hA500_0000;
  localparam logic [31:0] RES_OFS  = 32'h0000_1000;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  start_i = 1'b0;
  logic [CW-1:0]         total_jobs_i = '0;
  logic                  job_v_i = 1'b0;
  logic [JW-1:0]         job_data_i = '0;
  logic                  job_ready_o;
  logic [NODES-1:0]      node_v_o;
  logic [JW-1:0]         node_data_o;
  logic [NODES-1:0]      node_ready_i;
  logic [NODES-1:0]      node_done_i;
  logic [NODES*RW-1:0]   node_result_i;
  logic [NODES-1:0]      node_yumi_o;
  logic                  result_v_o;
  logic [RW-1:0]         result_data_o;
  logic [1:0]            result_node_o;
  logic                  result_yumi_i;
  logic [NODES-1:0]      busy_o;
  logic [CW-1:0]         jobs_done_o;
  logic                  all_done_o;
  logic                  timeout_o;

  logic                  auto_yumi = 1'b1;
  logic                  man_yumi  = 1'b0;
  logic [NODES-1:0]      inj_done  = '0;
  logic [NODES-1:0]      running, done;
  int                    lat [NODES];
  int                    cnt [NODES];
  logic [31:0]           mdata [NODES];

  int n_checks = 0, n_errors = 0;
  int disp_idx = 0, res_cnt = 0, cyc = 0, last_yumi_cyc = 0, to_cyc = 0;
  bit seen_to = 1'b0;

  always #5 clk = ~clk;

  bsg_kda_job_scheduler #(
    .nodes_p(NODES), .job_width_p(JW), .result_width_p(RW),
    .jobs_width_p(CW), .timeout_width_p(TW)
  ) dut (
    .clk_i(clk), .async_reset_n_i(rst_n), .start_i(start_i), .total_jobs_i(total_jobs_i),
    .job_v_i(job_v_i), .job_data_i(job_data_i), .job_ready_o(job_ready_o),
    .node_v_o(node_v_o), .node_data_o(node_data_o), .node_ready_i(node_ready_i),
    .node_done_i(node_done_i), .node_result_i(node_result_i), .node_yumi_o(node_yumi_o),
    .result_v_o(result_v_o), .result_data_o(result_data_o), .result_node_o(result_node_o),
    .result_yumi_i(result_yumi_i), .busy_o(busy_o), .jobs_done_o(jobs_done_o),
    .all_done_o(all_done_o), .timeout_o(timeout_o)
  );

  // Node model: starts on node_v_o, raises done lat cycles later (lat 0 = hang).
  assign node_ready_i  = ~running & ~done;
  assign node_done_i   = done | inj_done;
  assign result_yumi_i = auto_yumi ? result_v_o : man_yumi;

  always_comb begin
    node_result_i = '0;
    for (int k = 0; k < NODES; k++) node_result_i[k*RW +: RW] = mdata[k] + RES_OFS;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= '0;
      done    <= '0;
      for (int k = 0; k < NODES; k++) begin
        cnt[k]   <= 0;
        mdata[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NODES; k++) begin
        if (node_v_o[k]) begin
          running[k] <= 1'b1;
          cnt[k]     <= lat[k];
          mdata[k]   <= node_data_o;
        end else if (running[k] && lat[k] != 0) begin
          if (cnt[k] <= 1) begin
            running[k] <= 1'b0;
            done[k]    <= 1'b1;
          end else begin
            cnt[k] <= cnt[k] - 1;
          end
        end
        if (done[k] && node_yumi_o[k]) done[k] <= 1'b0;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor samples mid-low-phase, after the main thread has driven its stimulus.
  always begin
    logic [NODES-1:0] exp_oh;
    @(negedge clk);
    #2;
    cyc++;
    if (rst_n) begin
      if (node_v_o != '0) begin
        exp_oh = 4'b0001 << (disp_idx % NODES);
        check_eq("disp_node", 64'(node_v_o), 64'(exp_oh));
        check_eq("disp_data", 64'(node_data_o), 64'(JOB_BASE + 32'(disp_idx)));
        disp_idx++;
      end
      if (node_yumi_o != '0) last_yumi_cyc = cyc;
      if (result_v_o && result_yumi_i) begin
        check_eq("res_data", 64'(result_data_o), 64'(mdata[result_node_o] + RES_OFS));
        res_cnt++;
      end
      if (timeout_o && !seen_to) begin
        seen_to = 1'b1;
        to_cyc  = cyc;
      end
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; start_i = 1'b0; job_v_i = 1'b0; man_yumi = 1'b0; inj_done = '0;
    seen_to = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic start_batch(input int n);
    start_i = 1'b1; total_jobs_i = CW'(n);
    disp_idx = 0; res_cnt = 0;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic send_jobs(input int n);
    int guard;
    for (int j = 0; j < n; j++) begin
      job_v_i = 1'b1; job_data_i = JOB_BASE + 32'(j);
      guard = 0;
      while (!job_ready_o && guard < 300) begin
        @(negedge clk);
        guard++;
      end
      check_eq("job_ready", 64'(job_ready_o), 64'd1);
      @(negedge clk);
    end
    job_v_i = 1'b0;
  endtask

  task automatic wait_all_done(input int bound, input string tag);
    int g;
    g = 0;
    while (!all_done_o && g < bound) begin
      @(negedge clk);
      g++;
    end
    check_eq(tag, 64'(all_done_o), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: got running expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    int g;
    for (int k = 0; k < NODES; k++) lat[k] = 10;
    repeat (2) @(negedge clk);

    // Reset values
    check_eq("rst_outs_a", 64'({node_v_o, node_yumi_o, busy_o, job_ready_o, result_v_o, all_done_o, timeout_o}), 64'd0);
    check_eq("rst_outs_b", 64'({jobs_done_o, result_node_o}), 64'd0);
    check_eq("rst_data", 64'({node_data_o, result_data_o}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_no_ready", 64'(job_ready_o), 64'd0);

    // Full batch of 8 across 4 nodes
    start_batch(8);
    send_jobs(8);
    wait_all_done(400, "t1_all_done");
    check_eq("t1_jobs_done", 64'(jobs_done_o), 64'd8);
    check_eq("t1_dispatches", 64'(disp_idx), 64'd8);
    check_eq("t1_results", 64'(res_cnt), 64'd8);
    check_eq("t1_busy", 64'(busy_o), 64'd0);
    check_eq("t1_timeout", 64'(timeout_o), 64'd0);

    // Zero-length batch
    apply_reset();
    check_eq("t2_pre_done", 64'(all_done_o), 64'd0);
    start_batch(0);
    check_eq("t2_all_done", 64'(all_done_o), 64'd1);
    check_eq("t2_ready", 64'(job_ready_o), 64'd0);
    repeat (5) @(negedge clk);
    check_eq("t2_no_disp", 64'(disp_idx), 64'd0);

    // done pulse on an idle node is ignored
    inj_done = 4'b0100;
    #1;
    check_eq("t6_no_yumi", 64'(node_yumi_o), 64'd0);
    @(negedge clk);
    inj_done = '0;
    check_eq("t6_no_result", 64'(result_v_o), 64'd0);
    @(negedge clk);
    check_eq("t6_jobs_done", 64'(jobs_done_o), 64'd0);

    // Nodes 1 and 3 complete together, downstream stalls
    apply_reset();
    lat[0] = 30; lat[1] = 12; lat[2] = 30; lat[3] = 10;
    auto_yumi = 1'b0;
    start_batch(4);
    send_jobs(4);
    g = 0;
    while (!result_v_o && g < 100) begin
      @(negedge clk);
      g++;
    end
    check_eq("t3_first_node", 64'(result_node_o), 64'd1);
    check_eq("t3_first_data", 64'(result_data_o), 64'(JOB_BASE + 32'd1 + RES_OFS));
    check_eq("t3_busy_a", 64'(busy_o), 64'b1101);
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      check_eq("t3_stall_yumi", 64'(node_yumi_o), 64'd0);
      check_eq("t3_stall_node", 64'(result_node_o), 64'd1);
    end
    man_yumi = 1'b1;
    #1;
    check_eq("t3_yumi3", 64'(node_yumi_o), 64'b1000);
    @(negedge clk);
    man_yumi = 1'b0;
    check_eq("t3_second_node", 64'(result_node_o), 64'd3);
    check_eq("t3_second_data", 64'(result_data_o), 64'(JOB_BASE + 32'd3 + RES_OFS));
    check_eq("t3_jobs_done", 64'(jobs_done_o), 64'd1);
    check_eq("t3_busy_b", 64'(busy_o), 64'b0101);
    auto_yumi = 1'b1;
    wait_all_done(300, "t3_all_done");
    check_eq("t3_total", 64'(jobs_done_o), 64'd4);
    for (int k = 0; k < NODES; k++) lat[k] = 10;

    // Asynchronous reset in the middle of a batch
    apply_reset();
    start_batch(8);
    send_jobs(2);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("t5_async_a", 64'({node_v_o, node_yumi_o, busy_o, job_ready_o, result_v_o}), 64'd0);
    check_eq("t5_async_b", 64'({jobs_done_o, all_done_o, timeout_o}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_batch(2);
    send_jobs(2);
    wait_all_done(200, "t5_all_done");
    check_eq("t5_jobs_done", 64'(jobs_done_o), 64'd2);
    check_eq("t5_dispatches", 64'(disp_idx), 64'd2);

    // Watchdog: node 2 never completes
    apply_reset();
    lat[2] = 0;
    start_batch(3);
    send_jobs(3);
    g = 0;
    while (!timeout_o && g < 1000) begin
      @(negedge clk);
      g++;
    end
    check_eq("t4_timeout", 64'(timeout_o), 64'd1);
    @(negedge clk);
    check_eq("t4_latency", 64'(to_cyc - last_yumi_cyc), 64'd257);
    check_eq("t4_ready", 64'(job_ready_o), 64'd0);
    check_eq("t4_busy", 64'(busy_o), 64'b0100);
    check_eq("t4_jobs_done", 64'(jobs_done_o), 64'd2);
    check_eq("t4_all_done", 64'(all_done_o), 64'd0);
    start_batch(1);
    @(negedge clk);
    check_eq("t4_start_ignored", 64'({timeout_o, all_done_o}), 64'b10);
    job_v_i = 1'b1;
    #1;
    check_eq("t4_ready_err", 64'(job_ready_o), 64'd0);
    check_eq("t4_node_v_err", 64'(node_v_o), 64'd0);
    job_v_i = 1'b0;
    apply_reset();
    check_eq("t4_cleared", 64'(timeout_o), 64'd0);
    lat[2] = 10;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
